// File: rtl/correlation_stream_max.sv
// Streams NUM_CAND candidate words against a latched target and reports the
// candidate with the highest bit-agreement score plus the count at or above a threshold.
module correlation_stream_max #(
   parameter int WIDTH    = 32,
   parameter int NUM_CAND = 16,
   parameter int IDX_W    = 4,
   parameter int SCORE_W  = 6
) (
   input  logic               Clock,
   input  logic               Reset,
   input  logic               Start,
   input  logic [WIDTH-1:0]   Target,
   input  logic [SCORE_W-1:0] Threshold,
   input  logic               Cand_Valid,
   input  logic [WIDTH-1:0]   Cand_Data,
   output logic               Cand_Ready,
   output logic [IDX_W-1:0]   Best_Idx,
   output logic [SCORE_W-1:0] Best_Score,
   output logic [IDX_W:0]     Match_Count,
   output logic               Done,
   output logic               Busy
);

   localparam int CNT_W = IDX_W + 1;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCUM  = 2'd1,
      REPORT = 2'd2
   } state_t;

   function automatic logic [SCORE_W-1:0] f_score(input logic [WIDTH-1:0] a,
                                                  input logic [WIDTH-1:0] b);
      logic [SCORE_W-1:0] v_sum;
      v_sum = '0;
      for (int i = 0; i < WIDTH; i++) begin
         v_sum = v_sum + SCORE_W'(a[i] ~^ b[i]);
      end
      return v_sum;
   endfunction

   state_t             r_state;
   logic [WIDTH-1:0]   r_target;
   logic [SCORE_W-1:0] r_thresh;
   logic [CNT_W-1:0]   r_cnt;
   logic               r_ready;
   logic               r_stg_valid;
   logic               r_stg_last;
   logic [IDX_W-1:0]   r_stg_idx;
   logic [SCORE_W-1:0] r_stg_score;
   logic [IDX_W-1:0]   r_best_idx;
   logic [SCORE_W-1:0] r_best_score;
   logic [CNT_W-1:0]   r_match;
   logic [IDX_W-1:0]   r_out_idx;
   logic [SCORE_W-1:0] r_out_score;
   logic [CNT_W-1:0]   r_out_match;
   logic               r_done;
   logic               r_busy;

   logic               w_accept;
   logic [SCORE_W-1:0] w_score;
   logic               w_last;

   // r_ready is only ever high in ACCUM, so Start+Cand_Valid in IDLE never consumes a candidate.
   assign w_accept = Cand_Valid & r_ready;
   assign w_score  = f_score(Cand_Data, r_target);
   assign w_last   = (r_cnt == CNT_W'(NUM_CAND - 1));

   // Frame FSM with accept stage, compare/update stage and registered result outputs.
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         r_state      <= IDLE;
         r_target     <= '0;
         r_thresh     <= '0;
         r_cnt        <= '0;
         r_ready      <= 1'b0;
         r_stg_valid  <= 1'b0;
         r_stg_last   <= 1'b0;
         r_stg_idx    <= '0;
         r_stg_score  <= '0;
         r_best_idx   <= '0;
         r_best_score <= '0;
         r_match      <= '0;
         r_out_idx    <= '0;
         r_out_score  <= '0;
         r_out_match  <= '0;
         r_done       <= 1'b0;
         r_busy       <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            IDLE: begin
               r_stg_valid <= 1'b0;
               if (Start) begin
                  r_target     <= Target;
                  r_thresh     <= Threshold;
                  r_cnt        <= '0;
                  r_best_idx   <= '0;
                  r_best_score <= '0;
                  r_match      <= '0;
                  r_ready      <= 1'b1;
                  r_busy       <= 1'b1;
                  r_state      <= ACCUM;
               end
            end
            ACCUM: begin
               r_stg_valid <= w_accept;
               if (w_accept) begin
                  r_stg_idx   <= r_cnt[IDX_W-1:0];
                  r_stg_score <= w_score;
                  r_stg_last  <= w_last;
                  r_cnt       <= r_cnt + CNT_W'(1);
                  r_ready     <= ~w_last;
               end
               if (r_stg_valid) begin
                  // Strict greater-than keeps the lowest index on ties; index 0 always loads.
                  if ((r_stg_idx == IDX_W'(0)) || (r_stg_score > r_best_score)) begin
                     r_best_idx   <= r_stg_idx;
                     r_best_score <= r_stg_score;
                  end
                  if (r_stg_score >= r_thresh) begin
                     r_match <= r_match + CNT_W'(1);
                  end
                  if (r_stg_last) begin
                     r_state <= REPORT;
                  end
               end
            end
            REPORT: begin
               r_out_idx   <= r_best_idx;
               r_out_score <= r_best_score;
               r_out_match <= r_match;
               r_done      <= 1'b1;
               r_busy      <= 1'b0;
               r_ready     <= 1'b0;
               r_stg_valid <= 1'b0;
               r_state     <= IDLE;
            end
            default: begin
               r_state     <= IDLE;
               r_ready     <= 1'b0;
               r_busy      <= 1'b0;
               r_stg_valid <= 1'b0;
            end
         endcase
      end
   end

   assign Cand_Ready  = r_ready;
   assign Best_Idx    = r_out_idx;
   assign Best_Score  = r_out_score;
   assign Match_Count = r_out_match;
   assign Done        = r_done;
   assign Busy        = r_busy;

endmodule

// File: tb/tb_correlation_stream_max.sv
// Directed self-checking bench for correlation_stream_max with hand-computed results.
module tb_correlation_stream_max;

   logic        Clock = 1'b0;
   logic        Reset;
   logic        Start;
   logic [31:0] Target;
   logic [5:0]  Threshold;
   logic        Cand_Valid;
   logic [31:0] Cand_Data;
   logic        Cand_Ready;
   logic [3:0]  Best_Idx;
   logic [5:0]  Best_Score;
   logic [4:0]  Match_Count;
   logic        Done;
   logic        Busy;

   int n_checks = 0;
   int n_fails  = 0;

   logic [31:0] cand [16];
   logic [3:0]  prev_idx;
   logic [5:0]  prev_score;
   logic [4:0]  prev_match;

   correlation_stream_max #(
      .WIDTH(32), .NUM_CAND(16), .IDX_W(4), .SCORE_W(6)
   ) dut (
      .Clock      (Clock),
      .Reset      (Reset),
      .Start      (Start),
      .Target     (Target),
      .Threshold  (Threshold),
      .Cand_Valid (Cand_Valid),
      .Cand_Data  (Cand_Data),
      .Cand_Ready (Cand_Ready),
      .Best_Idx   (Best_Idx),
      .Best_Score (Best_Score),
      .Match_Count(Match_Count),
      .Done       (Done),
      .Busy       (Busy)
   );

   always #5 Clock = ~Clock;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge Clock);
      #1;
   endtask

   task automatic set_scn1();
      for (int i = 0; i < 16; i++) cand[i] = (i == 5) ? 32'hA5A5_A5A5 : 32'h5A5A_5A5A;
   endtask

   task automatic run_frame(input string name, input logic [31:0] tgt, input logic [5:0] thr,
                            input bit gaps, input bit start_busy, input bit extra17,
                            input logic [3:0] e_idx, input logic [5:0] e_score,
                            input logic [4:0] e_match);
      int i;
      int budget;
      Start      = 1'b1;
      Target     = tgt;
      Threshold  = thr;
      Cand_Valid = 1'b1;
      Cand_Data  = cand[0];
      tick();
      Start = 1'b0;
      check({name, "_busy_after_start"}, 32'(Busy), 32'd1);
      check({name, "_ready_after_start"}, 32'(Cand_Ready), 32'd1);
      check({name, "_hold_idx"}, 32'(Best_Idx), 32'(prev_idx));
      check({name, "_hold_score"}, 32'(Best_Score), 32'(prev_score));
      i = 0;
      budget = 0;
      while (i < 16 && budget < 400) begin
         if (gaps && $urandom_range(0, 2) == 0) begin
            Cand_Valid = 1'b0;
         end else begin
            Cand_Valid = 1'b1;
            Cand_Data  = cand[i];
            i++;
         end
         if (start_busy && i == 3) begin
            Start     = 1'b1;
            Target    = ~tgt;
            Threshold = 6'd0;
         end else begin
            Start = 1'b0;
         end
         tick();
         budget++;
      end
      check({name, "_all_accepted"}, 32'(i), 32'd16);
      Start      = 1'b0;
      Cand_Valid = extra17;
      Cand_Data  = 32'h0000_0000;
      check({name, "_ready_low_after_16"}, 32'(Cand_Ready), 32'd0);
      tick();
      check({name, "_done_early"}, 32'(Done), 32'd0);
      check({name, "_busy_mid"}, 32'(Busy), 32'd1);
      tick();
      check({name, "_done"}, 32'(Done), 32'd1);
      check({name, "_busy_fall"}, 32'(Busy), 32'd0);
      check({name, "_idx"}, 32'(Best_Idx), 32'(e_idx));
      check({name, "_score"}, 32'(Best_Score), 32'(e_score));
      check({name, "_match"}, 32'(Match_Count), 32'(e_match));
      tick();
      check({name, "_done_one_cycle"}, 32'(Done), 32'd0);
      check({name, "_ready_idle"}, 32'(Cand_Ready), 32'd0);
      check({name, "_idx_hold"}, 32'(Best_Idx), 32'(e_idx));
      Cand_Valid = 1'b0;
      prev_idx   = e_idx;
      prev_score = e_score;
      prev_match = e_match;
   endtask

   initial begin
      Reset = 1'b1; Start = 1'b0; Target = '0; Threshold = '0;
      Cand_Valid = 1'b0; Cand_Data = '0;
      prev_idx = '0; prev_score = '0; prev_match = '0;
      repeat (3) @(posedge Clock);
      #1;
      check("rst_ready", 32'(Cand_Ready), 32'd0);
      check("rst_done", 32'(Done), 32'd0);
      check("rst_busy", 32'(Busy), 32'd0);
      check("rst_idx", 32'(Best_Idx), 32'd0);
      check("rst_score", 32'(Best_Score), 32'd0);
      check("rst_match", 32'(Match_Count), 32'd0);
      @(negedge Clock);
      Reset = 1'b0;
      tick();

      // Exact match: only candidate 5 agrees fully, the rest score 0.
      set_scn1();
      run_frame("exact", 32'hA5A5_A5A5, 6'd16, 1'b0, 1'b0, 1'b0, 4'd5, 6'd32, 5'd1);

      // Tie: every candidate scores 24, lowest index wins.
      for (int k = 0; k < 16; k++) cand[k] = 32'h0000_00FF;
      run_frame("tie", 32'h0, 6'd24, 1'b0, 1'b0, 1'b0, 4'd0, 6'd24, 5'd16);

      // Graded: candidate i scores 32-i, threshold 28 admits i=0..4.
      for (int k = 0; k < 16; k++) cand[k] = (32'd1 << k) - 32'd1;
      run_frame("graded", 32'h0, 6'd28, 1'b0, 1'b0, 1'b0, 4'd0, 6'd32, 5'd5);

      // Same data with random gaps and a 17th candidate held valid.
      run_frame("gaps", 32'h0, 6'd28, 1'b1, 1'b0, 1'b1, 4'd0, 6'd32, 5'd5);

      // Start pulsed mid-frame with a different target must be ignored.
      set_scn1();
      run_frame("startbusy", 32'hA5A5_A5A5, 6'd16, 1'b0, 1'b1, 1'b0, 4'd5, 6'd32, 5'd1);

      // Reset after 7 accepted candidates, then a fresh frame.
      Start = 1'b1; Target = 32'hA5A5_A5A5; Threshold = 6'd16;
      tick();
      Start = 1'b0;
      for (int k = 0; k < 7; k++) begin
         Cand_Valid = 1'b1;
         Cand_Data  = cand[k];
         tick();
      end
      Cand_Valid = 1'b0;
      check("pre_reset_busy", 32'(Busy), 32'd1);
      #2;
      Reset = 1'b1;
      #1;
      check("async_rst_busy", 32'(Busy), 32'd0);
      check("async_rst_ready", 32'(Cand_Ready), 32'd0);
      check("async_rst_idx", 32'(Best_Idx), 32'd0);
      check("async_rst_score", 32'(Best_Score), 32'd0);
      check("async_rst_match", 32'(Match_Count), 32'd0);
      check("async_rst_done", 32'(Done), 32'd0);
      @(negedge Clock);
      Reset = 1'b0;
      Cand_Valid = 1'b1;
      Cand_Data  = cand[5];
      tick();
      tick();
      check("no_resume_busy", 32'(Busy), 32'd0);
      check("no_resume_ready", 32'(Cand_Ready), 32'd0);
      Cand_Valid = 1'b0;
      prev_idx = '0; prev_score = '0; prev_match = '0;
      run_frame("after_rst", 32'hA5A5_A5A5, 6'd16, 1'b0, 1'b0, 1'b0, 4'd5, 6'd32, 5'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule

// File: doc/correlation_stream_max.md
CORRELATION_STREAM_MAX -- requirements
Module: correlation_stream_max

Interface
REQ-001 The block SHALL have these parameters:
- WIDTH, default 32, bit width of target and candidate words.
- NUM_CAND, default 16, candidates per frame (≥2).
- IDX_W, default 4, index width; the integrator SHALL set IDX_W = clog2(NUM_CAND).
- SCORE_W, default 6, score width; the integrator SHALL set SCORE_W = clog2(WIDTH+1).

REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- Clock, in, 1, rising-edge clock. Reset, asynchronous, active-high; clock Clock.
- Reset, in, 1, asynchronous active-high reset.
- Start, in, 1, frame start request; sampled only in IDLE.
- Target, in, WIDTH, reference word; latched on an accepted Start.
- Threshold, in, SCORE_W, match threshold; latched on an accepted Start.
- Cand_Valid, in, 1, candidate word present.
- Cand_Data, in, WIDTH, candidate word.
- Cand_Ready, out, 1, block can accept a candidate.
- Best_Idx, out, IDX_W, arrival index (0-based) of the best candidate in the last frame.
- Best_Score, out, SCORE_W, score of the best candidate.
- Match_Count, out, IDX_W+1, number of candidates with score ≥ Threshold.
- Done, out, 1, one-cycle pulse when the result outputs update.
- Busy, out, 1, high when state is not IDLE.

Function
REQ-003 Score SHALL be the count of bit positions i where Cand_Data[i] == Target_latched[i], in the range 0..WIDTH, with no overflow at SCORE_W.
REQ-004 The FSM SHALL have three states: IDLE, ACCUM, REPORT.
- IDLE: Start=1 at an edge latches Target and Threshold, clears the candidate counter, running max and match counter, and moves to ACCUM.
REQ-005 A candidate SHALL be accepted at an edge only when Cand_Valid=1 and Cand_Ready=1.
- The accepted candidate takes index = counter value; the counter then increments.
REQ-006 Cand_Ready SHALL be a registered output, 1 only in ACCUM while fewer than NUM_CAND candidates have been accepted.
- Cand_Ready is 0 from the edge that accepts candidate NUM_CAND-1.
- Cand_Ready is 0 in IDLE and REPORT.
REQ-007 Scoring SHALL use a 2-stage pipeline.
- Edge k (accept): the score and index go into a stage register with a valid bit.
- Edge k+1: the compare and update of the running best and match counter occur.
REQ-008 The running best SHALL be replaced only when the new score is strictly greater than the running best score, so ties keep the lowest index.
- The first candidate of a frame always loads the running best.
REQ-009 The match counter SHALL increment at edge k+1 when the staged score ≥ Threshold_latched.
- Range is 0..NUM_CAND.
REQ-010 At the edge that compares candidate NUM_CAND-1 (edge k+1), the FSM SHALL move to REPORT.
REQ-011 REPORT SHALL copy the running results to Best_Idx, Best_Score and Match_Count, and pulse Done=1 for exactly one cycle.
- Done is visible after edge k+2 of the last acceptance.
- The FSM returns to IDLE on that same edge.
REQ-012 Best_Idx, Best_Score and Match_Count SHALL hold their values from the previous frame until the next Done.
REQ-013 Start SHALL be ignored when Busy=1, with no restart and no effect on the frame in progress.
REQ-014 Cand_Valid gaps SHALL be legal at any time; idle cycles only delay the result and never change it.
REQ-015 Start=1 and Cand_Valid=1 in the same IDLE cycle SHALL accept only the Start; the candidate is not consumed.
REQ-016 Busy SHALL be 1 in ACCUM and REPORT and 0 in IDLE.
- A new Start is accepted at the earliest on the edge after Done.

Reset
REQ-017 Reset=1 SHALL asynchronously force the following, regardless of state, including mid-frame:
- state = IDLE.
- Cand_Ready = 0, Done = 0, Busy = 0.
- Best_Idx = 0, Best_Score = 0, Match_Count = 0.
- The counter, pipeline valid bit, running best and latched registers are all cleared.
REQ-018 After Reset deasserts, a partial frame SHALL NOT resume; the next frame requires a new Start.

Verification
REQ-019 The bench SHALL cover these directed scenarios (defaults WIDTH=32, NUM_CAND=16):
- Exact match: Target=0xA5A5_A5A5; candidate 5 = Target; all others = ~Target → Best_Idx=5, Best_Score=32, Done pulses one cycle, Busy falls.
- Tie: Target=0; all 16 candidates = 0x0000_00FF → Best_Idx=0, Best_Score=24, Match_Count=16 with Threshold=24.
- Graded with threshold: Target=0; candidate i = (1<<i)-1, Threshold=28 → Best_Idx=0, Best_Score=32, Match_Count=5.
- Backpressure and gaps: scenario 3 with random Cand_Valid gaps → identical results; Cand_Ready=0 after the 16th acceptance; a 17th Cand_Valid is not consumed.
- Reset mid-frame: Reset after 7 accepted candidates → all outputs 0 immediately (asynchronously); a new Start with scenario 1 data → Best_Idx=5, Best_Score=32.
- Start while busy: pulse Start during ACCUM with a different Target → ignored; results match the original Target.
